// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Boot-stage image loader for the 16-bit RISC CPU. A byte stream arrives over
// a valid/ready handshake in the form
//     LEN_HI, LEN_LO, {DATA_HI, DATA_LO} x N, CHK
// where CHK is the XOR of all 2N data bytes. Each pair of data bytes becomes
// one big-endian 16-bit word, written to instruction memory at consecutive
// addresses from 0. The CPU is held in reset until a complete image with a
// matching checksum has been received.
//
// Handshake: a byte moves only on a rising edge where byte_valid && byte_ready.
// The producer keeps byte_in stable while byte_valid is high and not yet
// accepted. byte_ready is decoded from registered state only, so it never
// depends on byte_valid.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   start       single-cycle load request (honoured in IDLE, DONE, ERR)
//   byte_in     stream data
//   byte_valid  byte_in is valid
//   byte_ready  loader accepts a byte this cycle
//   imem_we     one-cycle instruction memory write strobe
//   imem_addr   write address
//   imem_wdata  write data
//   cpu_rst     active-high CPU reset, low only in DONE
//   done        image loaded and verified
//   err         load aborted (bad length or bad checksum)
//   word_count  words written in the current load
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam int WC_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] len;
    logic [7:0]  hi_byte;
    logic [7:0]  chk_acc;

    logic        xfer;
    logic        restart;
    logic [15:0] len_rx;
    logic        len_ok;
    logic [WC_W-1:0] wc_next;
    logic        last_word;

    assign xfer    = byte_valid && byte_ready;
    assign restart = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

    // Full length as it stands during the LEN_LO handshake (low byte not yet
    // registered), so the range check can pick the next state on that edge.
    assign len_rx  = {len[15:8], byte_in};
    assign len_ok  = (len_rx != 16'd0) && ({16'd0, len_rx} <= 32'(MAX_WORDS));

    // word_count after the current DATA_LO write; equal to N on the last word.
    assign wc_next   = word_count + WC_W'(1);
    assign last_word = ({{(32-WC_W){1'b0}}, wc_next} == {16'd0, len});

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_next = S_LEN_HI;
            S_LEN_HI:  if (xfer) state_next = S_LEN_LO;
            S_LEN_LO:  if (xfer) state_next = len_ok ? S_DATA_HI : S_ERR;
            S_DATA_HI: if (xfer) state_next = S_DATA_LO;
            S_DATA_LO: if (xfer) state_next = last_word ? S_CHK : S_DATA_HI;
            S_CHK:     if (xfer) state_next = (byte_in == chk_acc) ? S_DONE : S_ERR;
            default:   state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ state outputs
    always_comb begin
        byte_ready = 1'b0;
        cpu_rst    = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK: byte_ready = 1'b1;
            S_DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

    // ----------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            len        <= 16'd0;
            hi_byte    <= 8'd0;
            chk_acc    <= 8'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 16'd0;
            word_count <= '0;
        end else begin
            imem_we <= 1'b0;

            // The address steps on the edge that ends a write pulse. A pulse
            // seen in CHK belongs to the last word, so the address stays on
            // it rather than stepping past the top of memory.
            if (imem_we && state == S_DATA_HI) begin
                imem_addr <= imem_addr + ADDR_W'(1);
            end

            if (restart) begin
                len        <= 16'd0;
                chk_acc    <= 8'd0;
                imem_addr  <= '0;
                word_count <= '0;
            end

            if (xfer) begin
                case (state)
                    S_LEN_HI:  len[15:8] <= byte_in;
                    S_LEN_LO:  len[7:0]  <= byte_in;
                    S_DATA_HI: begin
                        hi_byte <= byte_in;
                        chk_acc <= chk_acc ^ byte_in;
                    end
                    S_DATA_LO: begin
                        imem_wdata <= {hi_byte, byte_in};
                        imem_we    <= 1'b1;
                        word_count <= wc_next;
                        chk_acc    <= chk_acc ^ byte_in;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
